// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: converts the PID drive magnitude into a period-synchronous PWM
// and drives a 3-phase brushless motor. Commutation comes from synchronized hall
// sensors. Each phase has a dead-time-protected high/low gate pair.
// Optional feature: define MTR_OC_CUTOFF_EN to add the oc_trip input. That
// input gives a cycle-by-cycle over-current cutoff of the high-side drives.
module mtr_drv_pwm #(
    parameter int DEAD_CYC = 32,
    parameter int FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MTR_OC_CUTOFF_EN
    input  logic        oc_trip,
`endif
    input  logic [11:0] drv_mag,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu,
    output logic        pwm_sync
);

    localparam int CW = (FAST_SIM != 0) ? 7 : 11;
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);

    typedef enum logic [1:0] {REQ_OFF, REQ_PWM, REQ_LO} req_t;
    typedef enum logic [1:0] {ST_OFF, ST_HI, ST_LO, ST_DEAD} state_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] duty_shadow;
    logic          cnt_wrap;
    logic          pwm_raw;
    logic [2:0]    hall_s1;
    logic [2:0]    hall_s2;
    req_t          req [3];
    logic [2:0]    hi_req;
    logic [2:0]    lo_req;
    logic          hi_block;
    state_t        state [3];
    logic [7:0]    dead_cnt [3];
    logic [2:0]    high_q;
    logic [2:0]    low_q;
    logic          unused_mag;

    // Low magnitude bits below the PWM resolution are intentionally dropped
    assign unused_mag = ^drv_mag[11-CW:0];
    assign cnt_wrap   = (cnt == {CW{1'b1}});

    // Free-running PWM counter; duty only updates at wrap so a period never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            duty_shadow <= '0;
            pwm_raw     <= 1'b0;
            pwm_sync    <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            pwm_sync <= cnt_wrap;
            pwm_raw  <= (cnt < duty_shadow);
            if (cnt_wrap)
                duty_shadow <= drv_mag[11 -: CW];
        end
    end

    // Two-flop synchronizer for the asynchronous hall inputs, ordered {G,Y,B}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_s1 <= 3'b000;
            hall_s2 <= 3'b000;
        end else begin
            hall_s1 <= {hallGrn, hallYlw, hallBlu};
            hall_s2 <= hall_s1;
        end
    end

    // Registered commutation decode; invalid codes coast with every phase off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 3; p++)
                req[p] <= REQ_OFF;
        end else begin
            case (hall_s2)
                3'b101:  begin req[0] <= REQ_PWM; req[1] <= REQ_LO;  req[2] <= REQ_OFF; end
                3'b100:  begin req[0] <= REQ_PWM; req[1] <= REQ_OFF; req[2] <= REQ_LO;  end
                3'b110:  begin req[0] <= REQ_OFF; req[1] <= REQ_PWM; req[2] <= REQ_LO;  end
                3'b010:  begin req[0] <= REQ_LO;  req[1] <= REQ_PWM; req[2] <= REQ_OFF; end
                3'b011:  begin req[0] <= REQ_LO;  req[1] <= REQ_OFF; req[2] <= REQ_PWM; end
                3'b001:  begin req[0] <= REQ_OFF; req[1] <= REQ_LO;  req[2] <= REQ_PWM; end
                default: begin req[0] <= REQ_OFF; req[1] <= REQ_OFF; req[2] <= REQ_OFF; end
            endcase
        end
    end

`ifdef MTR_OC_CUTOFF_EN
    logic oc_latched;

    // Over-current latch holds the high sides off until the next wrap; a trip wins over the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oc_latched <= 1'b0;
        else if (oc_trip)
            oc_latched <= 1'b1;
        else if (cnt_wrap)
            oc_latched <= 1'b0;
    end

    assign hi_block = oc_latched | oc_trip;
`else
    assign hi_block = 1'b0;
`endif

    // Per-phase gate requests; brake shorts the windings through the low sides at PWM rate
    always_comb begin
        hi_req = 3'b000;
        lo_req = 3'b000;
        for (int p = 0; p < 3; p++) begin
            if (!brake_n) begin
                lo_req[p] = pwm_raw;
            end else begin
                case (req[p])
                    REQ_PWM: begin
                        hi_req[p] = pwm_raw & ~hi_block;
                        lo_req[p] = ~pwm_raw;
                    end
                    REQ_LO:  lo_req[p] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Dead-time FSM per phase: every gate turn-on passes through DEAD_CYC clocks of both-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                state[p]    <= ST_OFF;
                dead_cnt[p] <= 8'd0;
            end
            high_q <= 3'b000;
            low_q  <= 3'b000;
        end else begin
            for (int p = 0; p < 3; p++) begin
                case (state[p])
                    ST_OFF: begin
                        if (hi_req[p] || lo_req[p]) begin
                            state[p]    <= ST_DEAD;
                            dead_cnt[p] <= DEAD_LOAD;
                        end
                    end
                    ST_HI: begin
                        if (!hi_req[p]) begin
                            state[p]    <= ST_DEAD;
                            dead_cnt[p] <= DEAD_LOAD;
                            high_q[p]   <= 1'b0;
                        end
                    end
                    ST_LO: begin
                        if (!lo_req[p]) begin
                            state[p]    <= ST_DEAD;
                            dead_cnt[p] <= DEAD_LOAD;
                            low_q[p]    <= 1'b0;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt[p] == 8'd0) begin
                            if (hi_req[p]) begin
                                state[p]  <= ST_HI;
                                high_q[p] <= 1'b1;
                            end else if (lo_req[p]) begin
                                state[p] <= ST_LO;
                                low_q[p] <= 1'b1;
                            end else begin
                                state[p] <= ST_OFF;
                            end
                        end else begin
                            dead_cnt[p] <= dead_cnt[p] - 8'd1;
                        end
                    end
                    default: begin
                        state[p]  <= ST_OFF;
                        high_q[p] <= 1'b0;
                        low_q[p]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign highGrn = high_q[0];
    assign lowGrn  = low_q[0];
    assign highYlw = high_q[1];
    assign lowYlw  = low_q[1];
    assign highBlu = high_q[2];
    assign lowBlu  = low_q[2];

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb_mtr_drv_pwm: self-checking bench for mtr_drv_pwm (DEAD_CYC=32, 11-bit PWM).
// Per-period gate on-time counts are queued as expectations and compared per period.
// Define MTR_OC_CUTOFF_EN to also exercise the over-current cutoff.
module tb_mtr_drv_pwm;

    localparam int DEAD_CYC = 32;
    localparam int PERIOD   = 2048;
    localparam int R_OFF = 0, R_PWM = 1, R_LO = 2, R_BRK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] drv_mag;
    logic        hallGrn, hallYlw, hallBlu, brake_n;
    logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_sync;
`ifdef MTR_OC_CUTOFF_EN
    logic        oc_trip;
`endif

    int check_count = 0;
    int error_count = 0;
    int exp_q[$];
    int period_no   = 0;
    int overlap_count = 0;
    int swap_count  = 0;
    int min_gap     = 1000000;
    int off_run [3];
    int last_side [3];

    string gate_names [7] = '{"highGrn", "lowGrn", "highYlw", "lowYlw", "highBlu", "lowBlu", "pwmSync"};
    logic [2:0] hall_seq [7] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b111};
    int role_tab [7][3] = '{'{R_PWM, R_LO,  R_OFF},
                            '{R_PWM, R_OFF, R_LO },
                            '{R_OFF, R_PWM, R_LO },
                            '{R_LO,  R_PWM, R_OFF},
                            '{R_LO,  R_OFF, R_PWM},
                            '{R_OFF, R_LO,  R_PWM},
                            '{R_OFF, R_OFF, R_OFF}};

    mtr_drv_pwm #(.DEAD_CYC(DEAD_CYC), .FAST_SIM(0)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MTR_OC_CUTOFF_EN
        .oc_trip  (oc_trip),
`endif
        .drv_mag  (drv_mag),
        .hallGrn  (hallGrn),
        .hallYlw  (hallYlw),
        .hallBlu  (hallBlu),
        .brake_n  (brake_n),
        .highGrn  (highGrn),
        .lowGrn   (lowGrn),
        .highYlw  (highYlw),
        .lowYlw   (lowYlw),
        .highBlu  (highBlu),
        .lowBlu   (lowBlu),
        .pwm_sync (pwm_sync)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // A PWM pulse of d clocks loses its first DEAD_CYC clocks to dead time
    function automatic int expHigh(input int role, input int d);
        return (role == R_PWM) ? d - DEAD_CYC : 0;
    endfunction

    function automatic int expLow(input int role, input int d);
        case (role)
            R_PWM:   return PERIOD - d - DEAD_CYC;
            R_LO:    return PERIOD;
            R_BRK:   return d - DEAD_CYC;
            default: return 0;
        endcase
    endfunction

    // Queue the expected per-period on-time counts for one steady period
    task automatic applyStimulus(input int r_g, input int r_y, input int r_b, input int d);
        exp_q.push_back(expHigh(r_g, d));
        exp_q.push_back(expLow(r_g, d));
        exp_q.push_back(expHigh(r_y, d));
        exp_q.push_back(expLow(r_y, d));
        exp_q.push_back(expHigh(r_b, d));
        exp_q.push_back(expLow(r_b, d));
        exp_q.push_back(1);
    endtask

    // Advance to the negedge inside the next pwm_sync cycle, bounded
    task automatic waitSync();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pwm_sync !== 1'b1 && n < 5000);
        if (pwm_sync !== 1'b1)
            checkOutput("syncTimeout", 0, 1);
    endtask

    // Count gate on-time across one period starting at a sync negedge, then pop and compare
    task automatic measurePeriod(input int change_at, input logic [11:0] new_mag, input int trip_at);
        int cnts [7];
        for (int k = 0; k < 7; k++) cnts[k] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clk);
            cnts[0] += int'(highGrn);
            cnts[1] += int'(lowGrn);
            cnts[2] += int'(highYlw);
            cnts[3] += int'(lowYlw);
            cnts[4] += int'(highBlu);
            cnts[5] += int'(lowBlu);
            cnts[6] += int'(pwm_sync);
            if (i == change_at) drv_mag = new_mag;
`ifdef MTR_OC_CUTOFF_EN
            if (i == trip_at) oc_trip = 1'b1;
            if (i == trip_at + 1) oc_trip = 1'b0;
`else
            if (i == trip_at) drv_mag = drv_mag;
`endif
        end
        period_no++;
        if (exp_q.size() < 7) begin
            checkOutput("sbUnderflow", exp_q.size(), 7);
            return;
        end
        for (int k = 0; k < 7; k++)
            checkOutput($sformatf("%s_p%0d", gate_names[k], period_no), cnts[k], exp_q.pop_front());
    endtask

    // Shoot-through and dead-gap monitor on every clock
    always @(negedge clk) begin
        logic [2:0] hi_v, lo_v;
        hi_v = {highBlu, highYlw, highGrn};
        lo_v = {lowBlu, lowYlw, lowGrn};
        for (int p = 0; p < 3; p++) begin
            if (rst) begin
                last_side[p] = 0;
                off_run[p]   = 0;
            end else begin
                if (hi_v[p] && lo_v[p]) overlap_count++;
                if (hi_v[p]) begin
                    if (last_side[p] == 2) begin
                        swap_count++;
                        if (off_run[p] < min_gap) min_gap = off_run[p];
                    end
                    last_side[p] = 1;
                    off_run[p]   = 0;
                end else if (lo_v[p]) begin
                    if (last_side[p] == 1) begin
                        swap_count++;
                        if (off_run[p] < min_gap) min_gap = off_run[p];
                    end
                    last_side[p] = 2;
                    off_run[p]   = 0;
                end else begin
                    off_run[p]++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv_mag = 12'h800;
        {hallGrn, hallYlw, hallBlu} = 3'b101;
        brake_n = 1'b1;
`ifdef MTR_OC_CUTOFF_EN
        oc_trip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, pwm_sync}), 0);
        rst = 1'b0;

        // Steady 50% drive on hall 101
        waitSync();
        applyStimulus(R_PWM, R_LO, R_OFF, 1024);
        waitSync();
        measurePeriod(-1, 12'h000, -1);

        // Duty change mid-period takes effect only at the next wrap
        waitSync();
        drv_mag = 12'h200;
        waitSync();
        applyStimulus(R_PWM, R_LO, R_OFF, 256);
        applyStimulus(R_PWM, R_LO, R_OFF, 1536);
        measurePeriod(100, 12'hC00, -1);
        waitSync();
        measurePeriod(-1, 12'h000, -1);

        // Step through every hall code, including the invalid 111
        waitSync();
        drv_mag = 12'h800;
        for (int k = 0; k < 7; k++) begin
            {hallGrn, hallYlw, hallBlu} = hall_seq[k];
            applyStimulus(role_tab[k][0], role_tab[k][1], role_tab[k][2], 1024);
            waitSync();
            measurePeriod(-1, 12'h000, -1);
            waitSync();
        end

        // Brake: all low sides at PWM rate, then release back to hall 101
        brake_n = 1'b0;
        drv_mag = 12'h400;
        {hallGrn, hallYlw, hallBlu} = 3'b101;
        applyStimulus(R_BRK, R_BRK, R_BRK, 512);
        waitSync();
        measurePeriod(-1, 12'h000, -1);
        waitSync();
        brake_n = 1'b1;
        drv_mag = 12'h800;
        applyStimulus(R_PWM, R_LO, R_OFF, 1024);
        waitSync();
        measurePeriod(-1, 12'h000, -1);

`ifdef MTR_OC_CUTOFF_EN
        // Over-current trip at cnt 300: Grn high from cnt DEAD_CYC+2 through 300 only
        waitSync();
        drv_mag = 12'hC00;
        exp_q.push_back(300 - (DEAD_CYC + 2) + 1);
        exp_q.push_back(PERIOD - 1536 - DEAD_CYC);
        exp_q.push_back(0);
        exp_q.push_back(PERIOD);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        waitSync();
        measurePeriod(-1, 12'h000, 300);
        drv_mag = 12'h800;
`endif

        // Asynchronous reset in the middle of a high pulse
        waitSync();
        repeat (500) @(negedge clk);
        checkOutput("preResetHighGrn", int'(highGrn), 1);
        rst = 1'b1;
        #1;
        checkOutput("midResetGates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drv_mag = 12'h800;
        waitSync();
        applyStimulus(R_PWM, R_LO, R_OFF, 1024);
        waitSync();
        measurePeriod(-1, 12'h000, -1);

        checkOutput("shootThrough", overlap_count, 0);
        checkOutput("deadGapOk", int'(swap_count > 0 && min_gap >= DEAD_CYC), 1);
        checkOutput("sbLeftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
